// File: rtl/mpf_vtp_mmio_rsp_pkg.sv
// Shared types and constants for the VTP / AFU MMIO read-response merge.
package mpf_vtp_mmio_rsp_pkg;

  localparam int unsigned CCIP_TID_WIDTH    = 9;
  localparam int unsigned MMIO64_DATA_WIDTH = 64;

  typedef logic [CCIP_TID_WIDTH-1:0] t_ccip_tid;

  // Default-width response payload; modules with a different TID width
  // declare their own local copy of this layout.
  typedef struct packed {
    t_ccip_tid                    tid;
    logic [MMIO64_DATA_WIDTH-1:0] data;
  } t_mmio64_rsp;

  // Round-robin priority encoding.
  localparam logic PRIO_VTP = 1'b0;
  localparam logic PRIO_AFU = 1'b1;

endpackage

// File: rtl/cci_mpf_prim_fifo_lutram.sv
// Small distributed-RAM FIFO with a combinational (or optionally registered)
// head; pushes become visible at the head on the following cycle.
module cci_mpf_prim_fifo_lutram #(
  parameter int unsigned N_DATA_BITS     = 32,
  parameter int unsigned N_ENTRIES       = 8,
  parameter bit          REGISTER_OUTPUT = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_DATA_BITS-1:0] enq_data,
  input  logic                   enq_en,
  output logic                   not_full,
  output logic [N_DATA_BITS-1:0] first,
  input  logic                   deq_en,
  output logic                   not_empty
);

  localparam int unsigned PTR_W = $clog2(N_ENTRIES);
  localparam int unsigned CNT_W = $clog2(N_ENTRIES + 1);

  logic [N_DATA_BITS-1:0] mem_q [N_ENTRIES];
  logic [PTR_W-1:0]       wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0]       cnt_d, cnt_q;
  logic                   enq_ok, deq_ok;

  assign not_full  = (cnt_q != CNT_W'(N_ENTRIES));
  assign not_empty = (cnt_q != '0);

  always_comb begin
    enq_ok   = enq_en && not_full;
    deq_ok   = deq_en && not_empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(enq_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(deq_ok);
    cnt_d    = cnt_q + CNT_W'(enq_ok) - CNT_W'(deq_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (enq_ok) mem_q[wr_ptr_q] <= enq_data;
  end

  if (REGISTER_OUTPUT) begin : g_reg_out
    logic [N_DATA_BITS-1:0] first_d, first_q;
    // Bypass a same-cycle write landing on the next head entry.
    always_comb begin
      first_d = mem_q[rd_ptr_d];
      if (enq_ok && (wr_ptr_q == rd_ptr_d)) first_d = enq_data;
    end
    always_ff @(posedge clk) first_q <= first_d;
    assign first = first_q;
  end else begin : g_comb_out
    assign first = mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/mpf_vtp_mmio_rsp_merge.sv
// Merges VTP CSR read responses with buffered AFU CSR read responses into a
// single registered MMIO response slot using round-robin arbitration.
module mpf_vtp_mmio_rsp_merge
  import mpf_vtp_mmio_rsp_pkg::*;
#(
  parameter int unsigned MMIO64_TID_WIDTH      = $bits(t_ccip_tid),
  parameter int unsigned AFU_FIFO_ENTRIES      = 64,
  parameter int unsigned AFU_ALMOST_FULL_SLOTS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         vtp_rsp_valid,
  input  logic [MMIO64_TID_WIDTH-1:0]  vtp_rsp_tid,
  input  logic [MMIO64_DATA_WIDTH-1:0] vtp_rsp_data,
  output logic                         vtp_rsp_deq,
  input  logic                         afu_rsp_valid,
  input  logic [MMIO64_TID_WIDTH-1:0]  afu_rsp_tid,
  input  logic [MMIO64_DATA_WIDTH-1:0] afu_rsp_data,
  output logic                         afu_almost_full,
  output logic                         afu_overflow,
  output logic                         mmio_rsp_valid,
  output logic [MMIO64_TID_WIDTH-1:0]  mmio_rsp_tid,
  output logic [MMIO64_DATA_WIDTH-1:0] mmio_rsp_data,
  input  logic                         mmio_rsp_ready
);

  localparam int unsigned RSP_W = MMIO64_TID_WIDTH + MMIO64_DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(AFU_FIFO_ENTRIES + 1);

  typedef struct packed {
    logic [MMIO64_TID_WIDTH-1:0]  tid;
    logic [MMIO64_DATA_WIDTH-1:0] data;
  } t_rsp;

  t_rsp             afu_in, afu_head;
  t_rsp             rsp_d, rsp_q;
  logic             rsp_valid_d, rsp_valid_q;
  logic             prio_d, prio_q;
  logic             af_d, af_q;
  logic             ovf_d, ovf_q;
  logic [CNT_W-1:0] afu_cnt_d, afu_cnt_q;
  logic             afu_not_full, afu_not_empty, afu_push;
  logic             slot_free, grant_vtp, grant_afu;

  assign afu_in = '{tid: afu_rsp_tid, data: afu_rsp_data};

  cci_mpf_prim_fifo_lutram #(
    .N_DATA_BITS     (RSP_W),
    .N_ENTRIES       (AFU_FIFO_ENTRIES),
    .REGISTER_OUTPUT (1'b0)
  ) u_afu_fifo (
    .clk       (clk),
    .reset     (reset),
    .enq_data  (afu_in),
    .enq_en    (afu_push),
    .not_full  (afu_not_full),
    .first     (afu_head),
    .deq_en    (grant_afu),
    .not_empty (afu_not_empty)
  );

  // Arbitration, output slot update and AFU occupancy tracking.
  always_comb begin
    slot_free   = !rsp_valid_q || mmio_rsp_ready;
    grant_vtp   = 1'b0;
    grant_afu   = 1'b0;
    prio_d      = prio_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;

    if (slot_free && !reset) begin
      if (vtp_rsp_valid && afu_not_empty) begin
        grant_vtp = (prio_q == PRIO_VTP);
        grant_afu = !grant_vtp;
        prio_d    = grant_vtp ? PRIO_AFU : PRIO_VTP;
      end else begin
        grant_vtp = vtp_rsp_valid;
        grant_afu = afu_not_empty;
      end
    end

    if (grant_vtp) begin
      rsp_valid_d = 1'b1;
      rsp_d       = '{tid: vtp_rsp_tid, data: vtp_rsp_data};
    end else if (grant_afu) begin
      rsp_valid_d = 1'b1;
      rsp_d       = afu_head;
    end else if (mmio_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    // A push against a full buffer is dropped even if a pop happens this cycle.
    afu_push  = afu_rsp_valid && afu_not_full;
    afu_cnt_d = afu_cnt_q + CNT_W'(afu_push) - CNT_W'(grant_afu);
    af_d      = (CNT_W'(AFU_FIFO_ENTRIES) - afu_cnt_d) <= CNT_W'(AFU_ALMOST_FULL_SLOTS);
    ovf_d     = ovf_q || (afu_rsp_valid && !afu_not_full);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      prio_q      <= PRIO_VTP;
      afu_cnt_q   <= '0;
      af_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      prio_q      <= prio_d;
      afu_cnt_q   <= afu_cnt_d;
      af_q        <= af_d;
      ovf_q       <= ovf_d;
    end
  end

  assign vtp_rsp_deq     = grant_vtp;
  assign mmio_rsp_valid  = rsp_valid_q;
  assign mmio_rsp_tid    = rsp_q.tid;
  assign mmio_rsp_data   = rsp_q.data;
  assign afu_almost_full = af_q;
  assign afu_overflow    = ovf_q;

endmodule
